// File: rtl/alu_arbiter_if.sv
// Bus between the ALU arbiter, its two requesters and the shared registered ALU.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the ALU.
interface alu_arbiter_if #(
    parameter int W  = 8,
    parameter int CW = 4
);
    logic          req0;
    logic          req1;
    logic [CW-1:0] op0;
    logic [CW-1:0] op1;
    logic [W-1:0]  a0;
    logic [W-1:0]  a1;
    logic [W-1:0]  b0;
    logic [W-1:0]  b1;
    logic          gnt0;
    logic          gnt1;
    logic          rsp_v0;
    logic          rsp_v1;
    logic [W-1:0]  rsp_d0;
    logic [W-1:0]  rsp_d1;
    logic          rsp_err0;
    logic          rsp_err1;
    logic          busy;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [CW-1:0] alu_ctr;
    logic [W-1:0]  alu_o;

    modport slave (
        input  req0, req1, op0, op1, a0, a1, b0, b1, alu_o,
        output gnt0, gnt1, rsp_v0, rsp_v1, rsp_d0, rsp_d1,
               rsp_err0, rsp_err1, busy, alu_a, alu_b, alu_ctr
    );

    modport master (
        output req0, req1, op0, op1, a0, a1, b0, b1, alu_o,
        input  gnt0, gnt1, rsp_v0, rsp_v1, rsp_d0, rsp_d1,
               rsp_err0, rsp_err1, busy, alu_a, alu_b, alu_ctr
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU between two requesters: grant, wait out
// the ALU latency, then return the captured result to the granted port.
module alu_arbiter #(
    parameter int W   = 8,
    parameter int CW  = 4,
    parameter int LAT = 2
) (
    input  logic         ck,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2
    } state_t;

    state_t         state_q;
    logic [CNT_W-1:0] cnt_q;
    logic           last_q;
    logic           win_q;
    logic           err_q;
    logic           gnt0_q;
    logic           gnt1_q;
    logic           rsp_v0_q;
    logic           rsp_v1_q;
    logic [W-1:0]   rsp_d0_q;
    logic [W-1:0]   rsp_d1_q;
    logic           rsp_err0_q;
    logic           rsp_err1_q;
    logic           busy_q;
    logic [W-1:0]   alu_a_q;
    logic [W-1:0]   alu_b_q;
    logic [CW-1:0]  alu_ctr_q;

    logic           take_s;
    logic           win_s;
    logic [CW-1:0]  sel_op_s;
    logic [W-1:0]   sel_a_s;
    logic [W-1:0]   sel_b_s;

    // Legal codes are 000x and 1xxx; everything from 0010 to 0111 is flagged.
    function automatic logic op_legal(input logic [CW-1:0] op);
        return op[CW-1] | (op[CW-2:1] == {(CW-2){1'b0}});
    endfunction

    // Winner selection: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        take_s = 1'b0;
        win_s  = 1'b0;
        if (bus.req0 && bus.req1) begin
            take_s = 1'b1;
            win_s  = ~last_q;
        end else if (bus.req0) begin
            take_s = 1'b1;
            win_s  = 1'b0;
        end else if (bus.req1) begin
            take_s = 1'b1;
            win_s  = 1'b1;
        end else begin
            take_s = 1'b0;
            win_s  = 1'b0;
        end
    end

    // Operand mux for the selected port.
    always_comb begin
        sel_op_s = bus.op0;
        sel_a_s  = bus.a0;
        sel_b_s  = bus.b0;
        if (win_s) begin
            sel_op_s = bus.op1;
            sel_a_s  = bus.a1;
            sel_b_s  = bus.b1;
        end else begin
            sel_op_s = bus.op0;
            sel_a_s  = bus.a0;
            sel_b_s  = bus.b0;
        end
    end

    // Arbiter FSM with all outputs registered; gnt and rsp_v are single-cycle strobes.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            last_q     <= 1'b1;
            win_q      <= 1'b0;
            err_q      <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rsp_v0_q   <= 1'b0;
            rsp_v1_q   <= 1'b0;
            rsp_d0_q   <= {W{1'b0}};
            rsp_d1_q   <= {W{1'b0}};
            rsp_err0_q <= 1'b0;
            rsp_err1_q <= 1'b0;
            busy_q     <= 1'b0;
            alu_a_q    <= {W{1'b0}};
            alu_b_q    <= {W{1'b0}};
            alu_ctr_q  <= {CW{1'b0}};
        end else begin
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            rsp_v0_q <= 1'b0;
            rsp_v1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take_s) begin
                        alu_a_q   <= sel_a_s;
                        alu_b_q   <= sel_b_s;
                        alu_ctr_q <= sel_op_s;
                        last_q    <= win_s;
                        win_q     <= win_s;
                        err_q     <= ~op_legal(sel_op_s);
                        gnt0_q    <= ~win_s;
                        gnt1_q    <= win_s;
                        cnt_q     <= {CNT_W{1'b0}};
                        busy_q    <= 1'b1;
                        state_q   <= WAIT;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                WAIT: begin
                    // The ALU needs LAT edges after alu_* settle; CAPT samples on the next one.
                    if (cnt_q == CNT_W'(LAT - 1)) begin
                        state_q <= CAPT;
                    end else begin
                        cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                CAPT: begin
                    if (win_q) begin
                        rsp_d1_q   <= bus.alu_o;
                        rsp_err1_q <= err_q;
                        rsp_v1_q   <= 1'b1;
                    end else begin
                        rsp_d0_q   <= bus.alu_o;
                        rsp_err0_q <= err_q;
                        rsp_v0_q   <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.rsp_v0   = rsp_v0_q;
    assign bus.rsp_v1   = rsp_v1_q;
    assign bus.rsp_d0   = rsp_d0_q;
    assign bus.rsp_d1   = rsp_d1_q;
    assign bus.rsp_err0 = rsp_err0_q;
    assign bus.rsp_err1 = rsp_err1_q;
    assign bus.busy     = busy_q;
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_ctr  = alu_ctr_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a two-stage registered ALU model (LAT=2).
module tb_alu_arbiter;
    localparam int W   = 8;
    localparam int CW  = 4;
    localparam int LAT = 2;

    typedef struct {
        logic [7:0] d;
        logic       err;
        int         gc;
    } exp_t;

    logic ck = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t pq [2][$];
    exp_t fq [2][$];
    int   go_q[$];

    alu_arbiter_if #(.W(W), .CW(CW)) bus ();

    alu_arbiter #(.W(W), .CW(CW), .LAT(LAT)) dut (
        .ck   (ck),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 ck = ~ck;
    always @(posedge ck) cyc++;

    // Shifts and rotates move by one bit; undefined codes give zero.
    function automatic logic [7:0] alu_f(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        case (c)
            4'b0000: return x + y;
            4'b0001: return x - y;
            4'b1000: return x & y;
            4'b1001: return x | y;
            4'b1010: return x ^ y;
            4'b1011: return ~x;
            4'b1100: return x >> 1;
            4'b1101: return x << 1;
            4'b1110: return {x[0], x[7:1]};
            4'b1111: return {x[6:0], x[7]};
            default: return 8'h00;
        endcase
    endfunction

    logic [7:0] alu_s1;
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            alu_s1    <= 8'h00;
            bus.alu_o <= 8'h00;
        end else begin
            alu_s1    <= alu_f(bus.alu_ctr, bus.alu_a, bus.alu_b);
            bus.alu_o <= alu_s1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor: grants move expectations into flight, responses are compared against them.
    logic       g[2];
    logic       v[2];
    logic [7:0] rd[2];
    logic       re[2];
    exp_t       mx;
    always @(negedge ck) begin
        if (rst_n) begin
            g[0] = bus.gnt0;    g[1] = bus.gnt1;
            v[0] = bus.rsp_v0;  v[1] = bus.rsp_v1;
            rd[0] = bus.rsp_d0; rd[1] = bus.rsp_d1;
            re[0] = bus.rsp_err0; re[1] = bus.rsp_err1;
            for (int p = 0; p < 2; p++) begin
                if (g[p]) begin
                    if (go_q.size() == 0 || pq[p].size() == 0) begin
                        chk($sformatf("unexpected_gnt%0d", p), 64'd1, 64'd0);
                    end else begin
                        chk("gnt_order", 64'(p), 64'(go_q.pop_front()));
                        mx = pq[p].pop_front();
                        mx.gc = cyc;
                        fq[p].push_back(mx);
                    end
                end
                if (v[p]) begin
                    if (fq[p].size() == 0) begin
                        chk($sformatf("unexpected_rsp_v%0d", p), 64'd1, 64'd0);
                    end else begin
                        mx = fq[p].pop_front();
                        chk($sformatf("rsp_d%0d", p), 64'(rd[p]), 64'(mx.d));
                        chk($sformatf("rsp_err%0d", p), 64'(re[p]), 64'(mx.err));
                        chk($sformatf("latency%0d", p), 64'(cyc - mx.gc), 64'(LAT + 1));
                    end
                end
            end
        end
    end

    task automatic set_port(input int p, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        if (p == 0) begin
            bus.op0 = op; bus.a0 = a; bus.b0 = b;
        end else begin
            bus.op1 = op; bus.a1 = a; bus.b1 = b;
        end
    endtask

    task automatic set_req(input int p, input logic r);
        if (p == 0) bus.req0 = r;
        else        bus.req1 = r;
    endtask

    task automatic expect_op(input int p, input logic [7:0] d, input logic err);
        exp_t x;
        x.d = d; x.err = err; x.gc = 0;
        pq[p].push_back(x);
        go_q.push_back(p);
    endtask

    task automatic wait_gnt(input int p, output int gc);
        bit seen = 1'b0;
        gc = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ck);
            if ((p == 0 && bus.gnt0) || (p == 1 && bus.gnt1)) begin
                seen = 1'b1;
                gc = cyc;
            end
        end
        if (!seen) chk($sformatf("gnt%0d_timeout", p), 64'd0, 64'd1);
    endtask

    task automatic issue(input int p, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic ee);
        int gc;
        expect_op(p, ed, ee);
        set_port(p, op, a, b);
        set_req(p, 1'b1);
        wait_gnt(p, gc);
        set_req(p, 1'b0);
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge ck);
            if (pq[0].size() == 0 && pq[1].size() == 0 && fq[0].size() == 0 &&
                fq[1].size() == 0 && !bus.busy) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.gnt0, bus.gnt1, bus.rsp_v0, bus.rsp_v1, bus.rsp_d0, bus.rsp_d1,
                    bus.rsp_err0, bus.rsp_err1, bus.busy, bus.alu_a, bus.alu_b, bus.alu_ctr});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int gcs[4];
    int ngr;
    int c0;
    int c1;
    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        set_port(0, 4'h0, 8'h00, 8'h00);
        set_port(1, 4'h0, 8'h00, 8'h00);
        repeat (2) @(posedge ck);
        #1;
        chk("reset_outs", all_outs(), 64'd0);
        rst_n = 1'b1;

        // Basic add on port 0.
        issue(0, 4'b0000, 8'h12, 8'h34, 8'h46, 1'b0);
        wait_done();

        // Wrap-around subtract, shifts, rotates and NOT.
        issue(1, 4'b0001, 8'h00, 8'h01, 8'hFF, 1'b0);
        issue(1, 4'b1110, 8'h81, 8'h00, 8'hC0, 1'b0);
        issue(1, 4'b1101, 8'h81, 8'h00, 8'h02, 1'b0);
        issue(0, 4'b1011, 8'h5A, 8'h00, 8'hA5, 1'b0);
        issue(0, 4'b1100, 8'h81, 8'h00, 8'h40, 1'b0);
        issue(1, 4'b1111, 8'h81, 8'h00, 8'h03, 1'b0);
        wait_done();

        // Both ports held high; last grant went to port 1, so order is 0,1,0,1.
        expect_op(0, 8'h30, 1'b0);
        expect_op(1, 8'hFF, 1'b0);
        expect_op(0, 8'hCC, 1'b0);
        expect_op(1, 8'hFF, 1'b0);
        set_port(0, 4'b1000, 8'hF0, 8'h3C);
        set_port(1, 4'b1001, 8'hF0, 8'h0F);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        ngr = 0;
        for (int i = 0; i < 40 && ngr < 4; i++) begin
            @(negedge ck);
            if (bus.gnt0 || bus.gnt1) begin
                gcs[ngr] = cyc;
                ngr++;
            end
            if (bus.gnt0) bus.op0 = 4'b1010;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("tie_grant_count", 64'(ngr), 64'd4);
        for (int i = 1; i < 4; i++) chk("tie_spacing", 64'(gcs[i] - gcs[i-1]), 64'(LAT + 2));
        wait_done();

        // Illegal opcode returns err with zero data; the next legal op clears err.
        issue(0, 4'b0101, 8'h12, 8'h34, 8'h00, 1'b1);
        issue(0, 4'b0000, 8'hFF, 8'h02, 8'h01, 1'b0);
        wait_done();
        chk("rsp_d1_held", 64'(bus.rsp_d1), 64'h0000_0000_0000_00FF);
        chk("rsp_err1_held", 64'(bus.rsp_err1), 64'd0);

        // Port 1 requests while port 0 is in flight; granted on the first IDLE edge.
        expect_op(0, 8'h30, 1'b0);
        set_port(0, 4'b0000, 8'h10, 8'h20);
        bus.req0 = 1'b1;
        wait_gnt(0, c0);
        bus.req0 = 1'b0;
        expect_op(1, 8'hF0, 1'b0);
        set_port(1, 4'b0001, 8'h10, 8'h20);
        bus.req1 = 1'b1;
        wait_gnt(1, c1);
        bus.req1 = 1'b0;
        chk("busy_defer_gnt1", 64'(c1 - c0), 64'(LAT + 2));
        wait_done();

        // Reset during WAIT aborts the operation; afterwards a tie goes to port 0.
        expect_op(0, 8'h02, 1'b0);
        set_port(0, 4'b0000, 8'h01, 8'h01);
        bus.req0 = 1'b1;
        wait_gnt(0, c0);
        bus.req0 = 1'b0;
        @(posedge ck);
        #2;
        rst_n = 1'b0;
        pq[0].delete(); pq[1].delete(); fq[0].delete(); fq[1].delete(); go_q.delete();
        #1;
        chk("abort_outs", all_outs(), 64'd0);
        repeat (2) @(posedge ck);
        #1;
        rst_n = 1'b1;
        expect_op(0, 8'h07, 1'b0);
        expect_op(1, 8'hFF, 1'b0);
        set_port(0, 4'b0000, 8'h03, 8'h04);
        set_port(1, 4'b1010, 8'hAA, 8'h55);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        ngr = 0;
        for (int i = 0; i < 30 && ngr < 2; i++) begin
            @(negedge ck);
            if (bus.gnt0) begin bus.req0 = 1'b0; ngr++; end
            if (bus.gnt1) begin bus.req1 = 1'b0; ngr++; end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("post_reset_grants", 64'(ngr), 64'd2);
        wait_done();
        repeat (6) @(negedge ck);
        chk("idle_busy", 64'(bus.busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
